multicycle_controller: RTL and testbench

Control FSM that sequences a multi-cycle RV32I datapath built from the team's shared components: PC register, unified byte-addressed memory, register file, ALU, immediate extender and multiplexers. Each instruction takes several clock cycles. The controller generates every write enable, mux select, ALUcontrol code and IMMslc code. It stalls on a memory-ready handshake. It replaces the single-cycle combinational decoder.

---
 rtl/multicycle_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 59 +++++
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// HALT exists only when MC_CTRL_TRAP_EN is defined.
package multicycle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    MEM_ADR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    JALR_ADR,
    JUMP,
    LUI_WB
`ifdef MC_CTRL_TRAP_EN
    , HALT
`endif
  } state_t;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [ALUC_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b101;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 3'b110;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALUY   = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps (op, funct3, funct7b5) to an ALU operation and branch polarity.
// MC_CTRL_TRAP_EN adds funct_bad for unsupported ALU/branch funct3 codes.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  output logic [ALUC_W-1:0] alu_control,
  output logic              br_inv,
  output logic              br_valid
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic              funct_bad
`endif
);

  // Branches compare via sub/slt/sltu; taken = zero ^ br_inv when br_valid
  always_comb begin
    alu_control = ALU_ADD;
    br_inv      = 1'b0;
    br_valid    = 1'b0;
`ifdef MC_CTRL_TRAP_EN
    funct_bad   = 1'b0;
`endif
    if (op == OP_BRANCH) begin
      br_valid = 1'b1;
      case (funct3)
        3'b000: alu_control = ALU_SUB;
        3'b001: begin alu_control = ALU_SUB;  br_inv = 1'b1; end
        3'b100: begin alu_control = ALU_SLT;  br_inv = 1'b1; end
        3'b101: alu_control = ALU_SLT;
        3'b110: begin alu_control = ALU_SLTU; br_inv = 1'b1; end
        3'b111: alu_control = ALU_SLTU;
        default: begin
          br_valid = 1'b0;
`ifdef MC_CTRL_TRAP_EN
          funct_bad = 1'b1;
`endif
        end
      endcase
    end else if (op == OP_R || op == OP_I) begin
      case (funct3)
        3'b000: alu_control = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010: alu_control = ALU_SLT;
        3'b011: alu_control = ALU_SLTU;
        3'b100: alu_control = ALU_XOR;
        3'b110: alu_control = ALU_OR;
        3'b111: alu_control = ALU_AND;
        default: begin
`ifdef MC_CTRL_TRAP_EN
          funct_bad = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with memory-ready stalls.
// Define MC_CTRL_TRAP_EN to trap unsupported encodings into HALT with a sticky illegal flag.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              IRWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic [SEL_W-1:0]  ALUSrcA,
  output logic [SEL_W-1:0]  ALUSrcB,
  output logic [SEL_W-1:0]  ResultSrc,
  output logic [ALUC_W-1:0] ALUcontrol,
  output logic [IMM_W-1:0]  IMMslc,
  output logic              illegal
);

  state_t state, next_state;
  logic [ALUC_W-1:0] dec_alu;
  logic br_inv, br_valid;
  logic pc_w, ir_w, mem_w, reg_w;
`ifdef MC_CTRL_TRAP_EN
  logic funct_bad;
`endif

  alu_decoder u_alu_decoder (
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu),
    .br_inv      (br_inv),
    .br_valid    (br_valid)
`ifdef MC_CTRL_TRAP_EN
    ,
    .funct_bad   (funct_bad)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  // Next state and per-state controls; unlisted controls stay 0
  always_comb begin
    next_state = state;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = RES_ALUOUT;
    ALUcontrol = ALU_ADD;
    IMMslc     = IMM_I;
    case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUY;
        pc_w      = mem_ready;
        ir_w      = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        IMMslc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_R:      next_state = EXEC_R;
          OP_I:      next_state = EXEC_I;
          OP_LW,
          OP_SW:     next_state = MEM_ADR;
          OP_BRANCH: next_state = BRANCH;
          OP_JAL:    next_state = JUMP;
          OP_JALR:   next_state = JALR_ADR;
          OP_LUI:    next_state = LUI_WB;
`ifdef MC_CTRL_TRAP_EN
          default:   next_state = HALT;
`else
          default:   next_state = FETCH;
`endif
        endcase
`ifdef MC_CTRL_TRAP_EN
        if (funct_bad) next_state = HALT;
`endif
      end
      EXEC_R: begin
        ALUSrcA    = SRCA_RS1;
        ALUcontrol = dec_alu;
        next_state = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUcontrol = dec_alu;
        next_state = ALU_WB;
      end
      ALU_WB: begin
        reg_w      = 1'b1;
        next_state = FETCH;
      end
      MEM_ADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        IMMslc     = (op == OP_SW) ? IMM_S : IMM_I;
        next_state = (op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next_state = MEM_WB;
      end
      MEM_WB: begin
        ResultSrc  = RES_MDR;
        reg_w      = 1'b1;
        next_state = FETCH;
      end
      MEM_WR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUcontrol = dec_alu;
        pc_w       = br_valid & (zero ^ br_inv);
        next_state = FETCH;
      end
      JALR_ADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = JUMP;
      end
      JUMP: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_w       = 1'b1;
        next_state = ALU_WB;
      end
      LUI_WB: begin
        IMMslc     = IMM_U;
        ResultSrc  = RES_IMM;
        reg_w      = 1'b1;
        next_state = FETCH;
      end
`ifdef MC_CTRL_TRAP_EN
      HALT: next_state = HALT;
`endif
      default: next_state = FETCH;
    endcase
  end

  // Enables drop the instant reset asserts, without waiting for a clock
  assign PCWrite  = rst & pc_w;
  assign IRWrite  = rst & ir_w;
  assign MemWrite = rst & mem_w;
  assign RegWrite = rst & reg_w;

`ifdef MC_CTRL_TRAP_EN
  assign illegal = rst & (state == HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle stimulus and expected controls are queued, then replayed.
// Honors MC_CTRL_TRAP_EN to choose between trap and NOP expectations.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       memw;
    logic       regw;
    logic       ill;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [2:0] aluc;
    logic [2:0] imm;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       rdy;
    logic       z;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUcontrol, IMMslc;

  int total  = 0;
  int passed = 0;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  string tag_q[$];

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUcontrol (ALUcontrol),
    .IMMslc     (IMMslc),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks so far %0d", total);
    $fatal(1);
  end

  // Expected control vectors per FSM state
  function automatic exp_t ph_fetch(input logic rdy);
    exp_t e = '0;
    e.pcw = rdy; e.irw = rdy; e.srcb = 2'b10; e.res = 2'b10;
    return e;
  endfunction
  function automatic exp_t ph_decode(input logic jal);
    exp_t e = '0;
    e.srca = 2'b01; e.srcb = 2'b01; e.imm = jal ? 3'b011 : 3'b010;
    return e;
  endfunction
  function automatic exp_t ph_exec(input logic imm_src, input logic [2:0] aluc);
    exp_t e = '0;
    e.srca = 2'b10; e.srcb = imm_src ? 2'b01 : 2'b00; e.aluc = aluc;
    return e;
  endfunction
  function automatic exp_t ph_alu_wb();
    exp_t e = '0;
    e.regw = 1'b1;
    return e;
  endfunction
  function automatic exp_t ph_mem_adr(input logic sw);
    exp_t e = '0;
    e.srca = 2'b10; e.srcb = 2'b01; e.imm = sw ? 3'b001 : 3'b000;
    return e;
  endfunction
  function automatic exp_t ph_mem_rd();
    exp_t e = '0;
    e.adr = 1'b1;
    return e;
  endfunction
  function automatic exp_t ph_mem_wb();
    exp_t e = '0;
    e.res = 2'b01; e.regw = 1'b1;
    return e;
  endfunction
  function automatic exp_t ph_mem_wr();
    exp_t e = '0;
    e.adr = 1'b1; e.memw = 1'b1;
    return e;
  endfunction
  function automatic exp_t ph_branch(input logic [2:0] aluc, input logic taken);
    exp_t e = '0;
    e.srca = 2'b10; e.aluc = aluc; e.pcw = taken;
    return e;
  endfunction
  function automatic exp_t ph_jump();
    exp_t e = '0;
    e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1;
    return e;
  endfunction
  function automatic exp_t ph_lui();
    exp_t e = '0;
    e.imm = 3'b100; e.res = 2'b11; e.regw = 1'b1;
    return e;
  endfunction
  function automatic exp_t ph_halt();
    exp_t e = '0;
    e.ill = 1'b1;
    return e;
  endfunction

  function automatic exp_t observe();
    return {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal,
            ALUSrcA, ALUSrcB, ResultSrc, ALUcontrol, IMMslc};
  endfunction

  task automatic push(input string tag, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic rdy, input logic z, input exp_t e);
    stim_q.push_back({o, f3, f7, rdy, z});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive one queued cycle at the falling edge and sample just after
  task automatic step(output exp_t want, output exp_t got, output string tag);
    stim_t s;
    s    = stim_q.pop_front();
    want = exp_q.pop_front();
    tag  = tag_q.pop_front();
    @(negedge clk);
    op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.rdy; zero = s.z;
    #1;
    got = observe();
  endtask

  task automatic assert_reset();
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] aluc);
    push({tag, ":fetch"},  o, f3, f7, 1'b1, 1'b0, ph_fetch(1'b1));
    push({tag, ":decode"}, o, f3, f7, 1'b1, 1'b0, ph_decode(1'b0));
    push({tag, ":exec"},   o, f3, f7, 1'b1, 1'b0, ph_exec(o == OP_I, aluc));
    push({tag, ":wb"},     o, f3, f7, 1'b1, 1'b0, ph_alu_wb());
  endtask

  task automatic push_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic [2:0] aluc, input logic taken);
    push({tag, ":fetch"},  OP_BRANCH, f3, 1'b0, 1'b1, z, ph_fetch(1'b1));
    push({tag, ":decode"}, OP_BRANCH, f3, 1'b0, 1'b1, z, ph_decode(1'b0));
    push({tag, ":branch"}, OP_BRANCH, f3, 1'b0, 1'b1, z, ph_branch(aluc, taken));
  endtask

  task automatic push_lui(input string tag);
    push({tag, ":fetch"},  OP_LUI, 3'b000, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push({tag, ":decode"}, OP_LUI, 3'b000, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push({tag, ":wb"},     OP_LUI, 3'b000, 1'b0, 1'b1, 1'b0, ph_lui());
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
    #2 rst = 1'b0;
    #1;
    got = observe();
    total++;
    if (got !== ph_fetch(1'b0)) $display("FAIL reset_state: got %h want %h", got, ph_fetch(1'b0));
    else passed++;
    mem_ready = 1'b0;
    release_reset();
  endtask

  task automatic test_alu();
    exp_t want, got;
    string tag;
    push_alu("sub",   OP_R, 3'b000, 1'b1, 3'b001);
    push_alu("add",   OP_R, 3'b000, 1'b0, 3'b000);
    push_alu("and",   OP_R, 3'b111, 1'b0, 3'b010);
    push_alu("slt",   OP_R, 3'b010, 1'b0, 3'b101);
    push_alu("xori",  OP_I, 3'b100, 1'b0, 3'b100);
    push_alu("addi7", OP_I, 3'b000, 1'b1, 3'b000);
    push_alu("ori",   OP_I, 3'b110, 1'b0, 3'b011);
    push_alu("sltiu", OP_I, 3'b011, 1'b0, 3'b110);
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
    end
  endtask

  task automatic test_load_store();
    exp_t want, got;
    string tag;
    push("lw:fetch",  OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("lw:decode", OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push("lw:adr",    OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, ph_mem_adr(1'b0));
    push("lw:rd0",    OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, ph_mem_rd());
    push("lw:rd1",    OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, ph_mem_rd());
    push("lw:rd2",    OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, ph_mem_rd());
    push("lw:wb",     OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, ph_mem_wb());
    push("sw:fstall", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, ph_fetch(1'b0));
    push("sw:fetch",  OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("sw:decode", OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push("sw:adr",    OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_mem_adr(1'b1));
    push("sw:wr0",    OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, ph_mem_wr());
    push("sw:wr1",    OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_mem_wr());
    push_lui("lui_after_sw");
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
    end
  endtask

  task automatic test_branch();
    exp_t want, got;
    string tag;
    push_branch("bne_z1",  3'b001, 1'b1, 3'b001, 1'b0);
    push_branch("bne_z0",  3'b001, 1'b0, 3'b001, 1'b1);
    push_branch("beq_z1",  3'b000, 1'b1, 3'b001, 1'b1);
    push_branch("blt_z0",  3'b100, 1'b0, 3'b101, 1'b1);
    push_branch("bge_z0",  3'b101, 1'b0, 3'b101, 1'b0);
    push_branch("bltu_z1", 3'b110, 1'b1, 3'b110, 1'b0);
    push_branch("bgeu_z1", 3'b111, 1'b1, 3'b110, 1'b1);
    push_lui("lui_after_br");
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
    end
  endtask

  task automatic test_jump();
    exp_t want, got;
    string tag;
    push("jal:fetch",   OP_JAL, 3'b000, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("jal:decode",  OP_JAL, 3'b000, 1'b0, 1'b1, 1'b0, ph_decode(1'b1));
    push("jal:jump",    OP_JAL, 3'b000, 1'b0, 1'b1, 1'b0, ph_jump());
    push("jal:wb",      OP_JAL, 3'b000, 1'b0, 1'b1, 1'b0, ph_alu_wb());
    push("jalr:fetch",  OP_JALR, 3'b000, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("jalr:decode", OP_JALR, 3'b000, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push("jalr:adr",    OP_JALR, 3'b000, 1'b0, 1'b1, 1'b0, ph_exec(1'b1, 3'b000));
    push("jalr:jump",   OP_JALR, 3'b000, 1'b0, 1'b1, 1'b0, ph_jump());
    push("jalr:wb",     OP_JALR, 3'b000, 1'b0, 1'b1, 1'b0, ph_alu_wb());
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
    end
  endtask

  task automatic test_reset_midway();
    exp_t want, got;
    string tag;
    push("swr:fetch",  OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("swr:decode", OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push("swr:adr",    OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, ph_mem_adr(1'b1));
    push("swr:wr0",    OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, ph_mem_wr());
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
    end
    assert_reset();
    total++;
    if (MemWrite !== 1'b0) $display("FAIL midreset_memwrite: got %b want 0", MemWrite);
    else passed++;
    got = observe();
    total++;
    if (got !== ph_fetch(1'b0)) $display("FAIL midreset_state: got %h want %h", got, ph_fetch(1'b0));
    else passed++;
    release_reset();
    push_lui("lui_after_rst");
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    exp_t want, got;
    string tag;
`ifdef MC_CTRL_TRAP_EN
    push("ecall:fetch",  OP_SYSTEM, 3'b000, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("ecall:decode", OP_SYSTEM, 3'b000, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    for (int i = 0; i < 3; i++)
      push("ecall:halt", OP_LUI, 3'b000, 1'b0, 1'b1, 1'b1, ph_halt());
    push("sll:fetch",  OP_R, 3'b001, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("sll:decode", OP_R, 3'b001, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push("sll:halt",   OP_R, 3'b001, 1'b0, 1'b1, 1'b0, ph_halt());
    push("br010:fetch",  OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("br010:decode", OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push("br010:halt",   OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b0, ph_halt());
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
      if (want.ill && exp_q.size() != 0 && !exp_q[0].ill) begin
        assert_reset();
        got = observe();
        total++;
        if (got !== ph_fetch(1'b0)) $display("FAIL halt_reset: got %h want %h", got, ph_fetch(1'b0));
        else passed++;
        release_reset();
      end
    end
    assert_reset();
    total++;
    if (illegal !== 1'b0) $display("FAIL halt_final_reset: illegal got %b want 0", illegal);
    else passed++;
    release_reset();
`else
    push("ecall:fetch",  OP_SYSTEM, 3'b000, 1'b0, 1'b1, 1'b0, ph_fetch(1'b1));
    push("ecall:decode", OP_SYSTEM, 3'b000, 1'b0, 1'b1, 1'b0, ph_decode(1'b0));
    push_lui("lui_after_nop");
    push_alu("sll_as_add",  OP_R, 3'b001, 1'b0, 3'b000);
    push_alu("srli_as_add", OP_I, 3'b101, 1'b0, 3'b000);
    while (exp_q.size() != 0) begin
      step(want, got, tag);
      total++;
      if (got !== want) $display("FAIL %s: got %h want %h", tag, got, want);
      else passed++;
      total++;
      if (illegal !== 1'b0) $display("FAIL %s_illegal: got %b want 0", tag, illegal);
      else passed++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump();
    test_reset_midway();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
